seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 21 ++
 rtl/seq_divider_div_step.sv | 36 +++
 rtl/seq_divider.sv | 151 +++++++++++++++
 tb/tb_seq_divider.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_pkg
// Description : Shared types and constants for the sequential arithmetic
//               blocks (divider, and the Booth multiplier wrapper).
//               - state_t          : three-state control FSM encoding
//               - c_default_width  : default operand width
// Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    localparam int c_default_width = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_div_step
// Description : One combinational restoring-division step.
//               Ports:
//                 rem_in       [WIDTH:0]   partial remainder from the previous step
//                 dividend_bit             next dividend bit shifted in at the LSB
//                 divisor      [WIDTH-1:0] divisor magnitude
//                 rem_out      [WIDTH:0]   partial remainder after this step
//                 quo_bit                  quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             quo_bit
);

    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_diff;

    always_comb begin
        w_shifted = {rem_in, dividend_bit};
        w_diff    = w_shifted - {2'b00, divisor};
        // The extra top bit of the trial difference is its sign: a set bit
        // means the divisor did not fit, so the shifted value is restored.
        quo_bit   = ~w_diff[WIDTH+1];
        rem_out   = quo_bit ? w_diff[WIDTH:0] : w_shifted[WIDTH:0];
    end

endmodule : seq_divider_div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Signed sequential restoring divider, one quotient bit per
//               clock. Quotient truncates toward zero; remainder takes the
//               sign of the dividend.
//               Ports:
//                 clk, rst_n         clock, asynchronous active-low reset
//                 start              request, sampled only while idle
//                 a, b   [WIDTH-1:0] signed dividend / divisor
//                 busy               division in progress
//                 ready              results valid, held until next start
//                 quotient, remainder[WIDTH-1:0] signed results
//                 div_by_zero        b was zero (quotient -1, remainder a)
//                 overflow           most-negative / -1 (quotient wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int                 c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]   c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dvd;      // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0]   r_abs_b;
    logic [WIDTH:0]     r_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_b_zero;
    logic [WIDTH:0]     w_step_rem;
    logic               w_quo_bit;

    // Magnitudes are taken as unsigned WIDTH-bit values so the most-negative
    // operand maps to exactly 2^(WIDTH-1).
    assign w_abs_a  = a[WIDTH-1] ? -a : a;
    assign w_abs_b  = b[WIDTH-1] ? -b : b;
    assign w_b_zero = (b == '0);
    assign busy     = (r_state != IDLE);

    seq_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in       (r_rem),
        .dividend_bit (r_dvd[WIDTH-1]),
        .divisor      (r_abs_b),
        .rem_out      (w_step_rem),
        .quo_bit      (w_quo_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = w_b_zero ? FIX : CALC;
            CALC:    if (r_cnt == c_last) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_abs_b     <= '0;
            r_rem       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            ready       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt       <= '0;
                        r_dvd       <= w_abs_a;
                        r_abs_b     <= w_abs_b;
                        r_rem       <= '0;
                        r_neg_r     <= a[WIDTH-1];
                        r_neg_q     <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_dbz       <= w_b_zero;
                        r_ovf       <= (a == c_most_neg) && (b == '1);
                        ready       <= 1'b0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                CALC: begin
                    // Dividend bits leave at the MSB while quotient bits
                    // enter at the LSB of the same register.
                    r_rem <= w_step_rem;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_quo_bit};
                    r_cnt <= r_cnt + c_cnt_one;
                end
                FIX: begin
                    if (r_dbz) begin
                        // No steps ran, so r_dvd still holds |a|.
                        quotient  <= '1;
                        remainder <= r_neg_r ? -r_dvd : r_dvd;
                    end else begin
                        quotient  <= r_neg_q ? -r_dvd : r_dvd;
                        remainder <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                    end
                    ready       <= 1'b1;
                    div_by_zero <= r_dbz;
                    overflow    <= r_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider: directed vector table,
//               multi-cycle corner sequences and randomized operands against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int total  = 0;
    int passed = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .ready       (ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain integer division (truncating toward zero), wrapped
    // to W bits; zero divisor defined as quotient -1, remainder a.
    task automatic model(input logic [W-1:0] va, input logic [W-1:0] vb,
                         output vec_t v);
        int sa;
        int sb;
        sa = int'($signed(va));
        sb = int'($signed(vb));
        v.a  = va;
        v.b  = vb;
        v.dz = (sb == 0);
        v.ov = (sa == -(1 << (W-1))) && (sb == -1);
        if (sb == 0) begin
            v.q   = '1;
            v.r   = va;
            v.lat = 2;
        end else begin
            v.q   = W'(sa / sb);
            v.r   = W'(sa % sb);
            v.lat = W + 2;
        end
    endtask

    // Pulse start for one edge, scramble operands afterwards, and count
    // edges (accepting edge = 1) until ready rises, bounded.
    task automatic run_div(input logic [W-1:0] va, input logic [W-1:0] vb, output int lat);
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 1;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic compare(input string tag, input vec_t e, input int lat);
        check({tag, " latency"},   lat,         e.lat);
        check({tag, " quotient"},  quotient,    e.q);
        check({tag, " remainder"}, remainder,   e.r);
        check({tag, " div_by_zero"}, div_by_zero, e.dz);
        check({tag, " overflow"},  overflow,    e.ov);
    endtask

    vec_t tbl [10];

    initial begin
        vec_t e;
        int   lat;
        bit   seen;

        tbl[0] = '{16'd100,  16'd7,      16'd14,   16'd2,    1'b0, 1'b0, 18};
        tbl[1] = '{16'hFF9C, 16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18};
        tbl[2] = '{16'd7,    16'hFF9C,   16'd0,    16'd7,    1'b0, 1'b0, 18};
        tbl[3] = '{16'h8000, 16'hFFFF,   16'h8000, 16'd0,    1'b0, 1'b1, 18};
        tbl[4] = '{16'h8000, 16'd1,      16'h8000, 16'd0,    1'b0, 1'b0, 18};
        tbl[5] = '{16'd5,    16'd0,      16'hFFFF, 16'd5,    1'b1, 1'b0, 2};
        tbl[6] = '{16'h8000, 16'd0,      16'hFFFF, 16'h8000, 1'b1, 1'b0, 2};
        tbl[7] = '{16'hFFF9, 16'hFFFE,   16'd3,    16'hFFFF, 1'b0, 1'b0, 18};
        tbl[8] = '{16'h7FFF, 16'h8000,   16'd0,    16'h7FFF, 1'b0, 1'b0, 18};
        tbl[9] = '{16'h8000, 16'h8000,   16'd1,    16'd0,    1'b0, 1'b0, 18};

        // Reset state
        #12;
        check("reset outputs", {busy, ready, div_by_zero, overflow, quotient, remainder}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_div(tbl[i].a, tbl[i].b, lat);
            compare($sformatf("vec%0d", i), tbl[i], lat);
        end

        // Scenario A: start during busy is ignored
        @(negedge clk);
        a = 16'd100; b = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (3) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        a = 16'd9; b = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        while (!ready && lat < 40) begin @(posedge clk); #1; lat++; end
        compare("busy_start", tbl[0], lat);

        // Start on the FIX edge is ignored
        @(negedge clk);
        a = 16'd100; b = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        a = 16'd9; b = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("fix_edge ready/busy", {ready, busy}, 2'b10);
        @(posedge clk); #1;
        check("fix_edge held", {ready, busy, quotient}, {2'b10, 16'd14});

        // Start held over the FIX edge into IDLE is accepted in IDLE
        @(negedge clk);
        a = 16'd100; b = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        a = 16'd9; b = 16'd3; start = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        start = 1'b0;
        check("idle_accept ready/busy", {ready, busy}, 2'b01);
        lat = 1;
        while (!ready && lat < 40) begin @(posedge clk); #1; lat++; end
        model(16'd9, 16'd3, e);
        compare("idle_accept", e, lat);

        // Scenario B: reset mid-division aborts it
        @(negedge clk);
        a = 16'd100; b = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset outputs", {busy, ready, div_by_zero, overflow, quotient, remainder}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin @(posedge clk); #1; if (ready || busy) seen = 1'b1; end
        check("no ready after reset", seen, 1'b0);

        // Randomized operands against the reference model
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) rb = W'($urandom_range(1, 15));
            if (i % 8 == 1) rb = -W'($urandom_range(1, 15));
            if (i % 16 == 2) ra = 16'h8000;
            if (rb == '0) rb = 16'd1;
            model(ra, rb, e);
            run_div(ra, rb, lat);
            compare($sformatf("rand%0d a=%0h b=%0h", i, ra, rb), e, lat);
            if (!e.ov) begin
                int sq;
                int sr;
                int sa;
                int sb;
                sq = int'($signed(quotient));
                sr = int'($signed(remainder));
                sa = int'($signed(ra));
                sb = int'($signed(rb));
                check($sformatf("rand%0d identity", i),
                      {31'b0, (sq * sb + sr == sa)
                              && ((sr < 0 ? -sr : sr) < (sb < 0 ? -sb : sb))
                              && (sr == 0 || ((sr < 0) == (sa < 0)))},
                      32'd1);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire
